// File: rtl/quad_phase_decoder.sv
// ---------------------------------------------------------------------------
// quad_phase_decoder
//
// Decodes a 2-bit phase code coming from a free-running up/down counter on
// the far side of an asynchronous boundary.  Each legal +1/-1 change of the
// code becomes one step pulse plus a position update.  A jump of two
// positions is ambiguous, so it raises a sticky error flag instead.
//
// Ports
//   clk      in   1  single clock, all state on the rising edge
//   reset    in   1  synchronous, active-high
//   ph_in    in   2  phase code, asynchronous to clk
//   clr_err  in   1  clears err (a coincident illegal jump wins)
//   pos_clr  in   1  clears pos (a coincident step still pulses)
//   pos      out  8  accumulated step position, wraps modulo 256
//   dir      out  1  direction of last accepted step (0 = up, 1 = down)
//   step     out  1  one-cycle pulse per accepted step
//   err      out  1  sticky illegal-jump flag
//   valid    out  1  high while tracking
//
// Build option
//   QDEC_GLITCH_FILTER_EN : when defined, a synchronized sample is accepted
//   only after it has been stable for two consecutive cycles.  This adds one
//   cycle to both the fill time and the ph_in-to-step latency.
// ---------------------------------------------------------------------------
module quad_phase_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ph_in,
    input  logic       clr_err,
    input  logic       pos_clr,
    output logic [7:0] pos,
    output logic       dir,
    output logic       step,
    output logic       err,
    output logic       valid
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    // Last fill-counter value before leaving ST_FILL.  The fill time equals
    // the depth of the input pipeline, so the first sample loaded into
    // ph_prev is a real synchronized value rather than a reset zero.
`ifdef QDEC_GLITCH_FILTER_EN
    localparam logic [1:0] FILL_LAST = 2'd2;
`else
    localparam logic [1:0] FILL_LAST = 2'd1;
`endif

    logic [1:0] s1_reg;
    logic [1:0] s2_reg;
    logic [1:0] sample;
    logic [1:0] ph_prev_reg;
    logic [1:0] delta;
    logic [1:0] state_reg;
    logic [1:0] fill_cnt_reg;
    logic [7:0] pos_reg;
    logic       dir_reg;
    logic       step_reg;
    logic       err_reg;

    // Two-flop synchronizer: nothing downstream ever looks at ph_in directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= 2'b00;
            s2_reg <= 2'b00;
        end else begin
            s1_reg <= ph_in;
            s2_reg <= s1_reg;
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    logic [1:0] s3_reg;
    logic [1:0] accepted_reg;

    // A new value is believed only when it has survived two stages;
    // otherwise the previously accepted sample is reused.
    assign sample = (s2_reg == s3_reg) ? s2_reg : accepted_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_reg       <= 2'b00;
            accepted_reg <= 2'b00;
        end else begin
            s3_reg       <= s2_reg;
            accepted_reg <= sample;
        end
    end
`else
    assign sample = s2_reg;
`endif

    // Modulo-4 difference falls out of the 2-bit subtraction.
    assign delta = sample - ph_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_FILL;
            fill_cnt_reg <= 2'd0;
            ph_prev_reg  <= 2'b00;
            pos_reg      <= 8'h00;
            dir_reg      <= 1'b0;
            step_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            case (state_reg)
                ST_FILL: begin
                    if (fill_cnt_reg == FILL_LAST) begin
                        state_reg <= ST_LOAD;
                    end else begin
                        fill_cnt_reg <= fill_cnt_reg + 2'd1;
                    end
                end

                ST_LOAD: begin
                    ph_prev_reg <= sample;
                    state_reg   <= ST_TRACK;
                end

                ST_TRACK: begin
                    // ph_prev follows the sample even on an illegal jump so
                    // that tracking resumes from the new code afterwards.
                    ph_prev_reg <= sample;

                    if (delta == 2'd1) begin
                        step_reg <= 1'b1;
                        dir_reg  <= 1'b0;
                    end else if (delta == 2'd3) begin
                        step_reg <= 1'b1;
                        dir_reg  <= 1'b1;
                    end

                    if (pos_clr) begin
                        pos_reg <= 8'h00;
                    end else if (delta == 2'd1) begin
                        pos_reg <= pos_reg + 8'd1;
                    end else if (delta == 2'd3) begin
                        pos_reg <= pos_reg - 8'd1;
                    end

                    if (delta == 2'd2) begin
                        err_reg <= 1'b1;
                    end else if (clr_err) begin
                        err_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg    <= ST_FILL;
                    fill_cnt_reg <= 2'd0;
                end
            endcase
        end
    end

    assign pos   = pos_reg;
    assign dir   = dir_reg;
    assign step  = step_reg;
    assign err   = err_reg;
    assign valid = (state_reg == ST_TRACK);

endmodule

// File: tb/tb_quad_phase_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_phase_decoder
//
// Directed and randomized stimulus for quad_phase_decoder.  Expected values
// come from a small arithmetic model of the counter: every settled change of
// ph_in is turned into a modulo-4 difference that moves the expected
// position, direction, error flag and step count.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_quad_phase_decoder;

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int D = 3;
`else
    localparam int D = 2;
`endif
    localparam int LAT = D + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ph_in;
    logic       clr_err;
    logic       pos_clr;
    logic [7:0] pos;
    logic       dir;
    logic       step;
    logic       err;
    logic       valid;

    quad_phase_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .ph_in   (ph_in),
        .clr_err (clr_err),
        .pos_clr (pos_clr),
        .pos     (pos),
        .dir     (dir),
        .step    (step),
        .err     (err),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    // Reference model state
    int cur_ph;
    int exp_pos;
    int exp_dir;
    int exp_err;
    int exp_steps;

    // Step pulses are counted on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_change(input int v);
        int d;
        d = ((v - cur_ph) % 4 + 4) % 4;
        if (d == 1) begin
            exp_pos = (exp_pos + 1) % 256;
            exp_dir = 0;
            exp_steps++;
        end else if (d == 3) begin
            exp_pos = (exp_pos + 255) % 256;
            exp_dir = 1;
            exp_steps++;
        end else if (d == 2) begin
            exp_err = 1;
        end
        cur_ph = v;
    endtask

    task automatic apply(input int v, input int hold);
        ph_in = v[1:0];
        model_change(v);
        repeat (hold) tick();
    endtask

    task automatic verify(input string tag);
        check({tag, "_pos"},   {24'h0, pos},  exp_pos);
        check({tag, "_dir"},   {31'h0, dir},  exp_dir);
        check({tag, "_err"},   {31'h0, err},  exp_err);
        check({tag, "_steps"}, step_cnt,      exp_steps);
        $display("txn %-10s ph=%0d pos=%02h dir=%0d err=%0d steps=%0d", tag, ph_in, pos, dir, err, step_cnt);
    endtask

    initial begin
        reset   = 1'b1;
        ph_in   = 2'b10;
        clr_err = 1'b0;
        pos_clr = 1'b0;
        cur_ph = 2; exp_pos = 0; exp_dir = 0; exp_err = 0; exp_steps = 0;

        // Power-up
        tick();
        tick();
        reset = 1'b0;
        check("rst_pos",   {24'h0, pos},  0);
        check("rst_step",  {31'h0, step}, 0);
        check("rst_err",   {31'h0, err},  0);
        check("rst_valid", {31'h0, valid}, 0);
        repeat (D) tick();
        check("fill_valid", {31'h0, valid}, 0);
        tick();
        check("track_valid", {31'h0, valid}, 1);
        repeat (4) tick();
        verify("powerup");

        // Move legally to 00, then clear position
        apply(3, 5);
        apply(0, 5);
        verify("to_zero");
        pos_clr = 1'b1; tick(); pos_clr = 1'b0;
        exp_pos = 0;
        tick();
        verify("posclr");

        // Counting up and down
        apply(1, 5); apply(2, 5); apply(3, 5); apply(0, 5);
        verify("count_up");
        apply(3, 5); apply(2, 5);
        verify("count_dn");

        // Wrap
        pos_clr = 1'b1; tick(); pos_clr = 1'b0;
        exp_pos = 0;
        apply(1, 5);
        verify("wrap_dn");
        apply(2, 5);
        verify("wrap_up");
        apply(1, 5);
        verify("wrap_dn2");

        // Illegal jump 01 -> 11
        apply(3, 5);
        verify("illegal");
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        exp_err = 0;
        tick();
        check("clr_err", {31'h0, err}, 0);
        apply(0, 5);
        // clr_err coincides with the 00 -> 10 jump: set wins
        ph_in = 2'b10;
        model_change(2);
        repeat (LAT - 1) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("err_set_wins", {31'h0, err}, 1);
        repeat (5) tick();
        verify("set_wins");

        // Latency and one-cycle step width
        ph_in = 2'b11;
        model_change(3);
        repeat (LAT - 1) tick();
        check("lat_early", {31'h0, step}, 0);
        tick();
        check("lat_step", {31'h0, step}, 1);
        tick();
        check("lat_pulse", {31'h0, step}, 0);
        repeat (4) tick();
        verify("latency");

        // Reset mid-stream with a step in flight
        ph_in = 2'b10;
        repeat (LAT - 1) tick();
        reset = 1'b1;
        tick();
        check("mid_pos",   {24'h0, pos},   0);
        check("mid_dir",   {31'h0, dir},   0);
        check("mid_step",  {31'h0, step},  0);
        check("mid_err",   {31'h0, err},   0);
        check("mid_valid", {31'h0, valid}, 0);
        reset = 1'b0;
        cur_ph = 2; exp_pos = 0; exp_dir = 0; exp_err = 0;
        repeat (D + 1) tick();
        check("reinit_valid", {31'h0, valid}, 1);
        repeat (3) tick();
        verify("reinit");

        // pos_clr coincident with a step
        ph_in = 2'b11;
        model_change(3);
        repeat (LAT - 1) tick();
        pos_clr = 1'b1; tick(); pos_clr = 1'b0;
        exp_pos = 0;
        check("pclr_step", {31'h0, step}, 1);
        check("pclr_pos",  {24'h0, pos},  0);
        repeat (5) tick();
        verify("pclr_coin");

        // One-cycle glitch 00 -> 01 -> 00
        apply(0, 5);
        ph_in = 2'b01;
        tick();
        ph_in = 2'b00;
`ifndef QDEC_GLITCH_FILTER_EN
        exp_steps += 2;
        exp_dir = 1;
`endif
        repeat (6) tick();
        verify("glitch");

        // Randomized walk
        for (int i = 0; i < 40; i++) begin
            apply(int'($urandom_range(0, 3)), int'($urandom_range(5, 8)));
            verify("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
